// File: rtl/seg_shift_rx.sv
// seg_shift_rx: oversampling serial-to-parallel receiver that stands in for the
// board's display shift-register chain. Serial inputs are asynchronous to clk.
module seg_shift_rx #(
    parameter int unsigned WIDTH       = 64,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             RSTN,
    input  logic             s_clk,
    input  logic             s_dat,
    input  logic             s_pen,
    input  logic             s_clrn,
    output logic [WIDTH-1:0] par_out,
    output logic             frame_valid,
    output logic             frame_err,
    output logic             busy,
    output logic [15:0]      frame_cnt
);

    localparam int unsigned CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RECV = 2'd1;
    localparam logic [1:0] ST_FULL = 2'd2;
    localparam logic [1:0] ST_OVER = 2'd3;

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
    logic [SYNC_STAGES-1:0] pen_sync_q, pen_sync_d;
    logic [SYNC_STAGES-1:0] clrn_sync_q, clrn_sync_d;
    logic                   clk_last_q, clk_last_d;
    logic                   pen_last_q, pen_last_d;

    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    bitcnt_q, bitcnt_d;
    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] par_q, par_d;
    logic [15:0]      cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;

    logic s_clk_s, s_dat_s, s_pen_s, s_clrn_s;
    logic shift_rise, pen_rise;

    // Synchronizer chains and edge-detect history.
    always_comb begin
        clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], s_clk};
        dat_sync_d  = {dat_sync_q[SYNC_STAGES-2:0], s_dat};
        pen_sync_d  = {pen_sync_q[SYNC_STAGES-2:0], s_pen};
        clrn_sync_d = {clrn_sync_q[SYNC_STAGES-2:0], s_clrn};
        s_clk_s     = clk_sync_q[SYNC_STAGES-1];
        s_dat_s     = dat_sync_q[SYNC_STAGES-1];
        s_pen_s     = pen_sync_q[SYNC_STAGES-1];
        s_clrn_s    = clrn_sync_q[SYNC_STAGES-1];
        clk_last_d  = s_clk_s;
        pen_last_d  = s_pen_s;
        shift_rise  = s_clk_s & ~clk_last_q;
        pen_rise    = s_pen_s & ~pen_last_q;
    end

    // Frame FSM: apply the shift first, then decide the latch on post-shift state.
    always_comb begin
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        state_d  = state_q;
        par_d    = par_q;
        cnt_d    = cnt_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        if (!s_clrn_s) begin
            // Clear dominates both edges; the frame counter survives it.
            shreg_d  = '0;
            bitcnt_d = '0;
            par_d    = '0;
            state_d  = ST_IDLE;
        end else begin
            if (shift_rise) begin
                shreg_d = (shreg_q << 1) | WIDTH'(s_dat_s);
                if (bitcnt_q != CNT_MAX) begin
                    bitcnt_d = bitcnt_q + CW'(1);
                end
                case (state_q)
                    ST_IDLE: state_d = (WIDTH == 1) ? ST_FULL : ST_RECV;
                    ST_RECV: state_d = (bitcnt_q + CW'(1) == CNT_FULL) ? ST_FULL : ST_RECV;
                    ST_FULL: state_d = ST_OVER;
                    default: state_d = ST_OVER;
                endcase
            end
            if (pen_rise) begin
                case (state_d)
                    ST_FULL: begin
                        par_d    = shreg_d;
                        valid_d  = 1'b1;
                        cnt_d    = cnt_q + 16'd1;
                        state_d  = ST_IDLE;
                        bitcnt_d = '0;
                    end
                    ST_RECV, ST_OVER: begin
                        err_d    = 1'b1;
                        state_d  = ST_IDLE;
                        bitcnt_d = '0;
                    end
                    default: ;
                endcase
            end
        end
        busy_d = (state_d != ST_IDLE);
    end

    // State registers; the clear synchronizer resets to the inactive (high) level.
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            clk_sync_q  <= '0;
            dat_sync_q  <= '0;
            pen_sync_q  <= '0;
            clrn_sync_q <= '1;
            clk_last_q  <= 1'b0;
            pen_last_q  <= 1'b0;
            shreg_q     <= '0;
            bitcnt_q    <= '0;
            state_q     <= ST_IDLE;
            par_q       <= '0;
            cnt_q       <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            dat_sync_q  <= dat_sync_d;
            pen_sync_q  <= pen_sync_d;
            clrn_sync_q <= clrn_sync_d;
            clk_last_q  <= clk_last_d;
            pen_last_q  <= pen_last_d;
            shreg_q     <= shreg_d;
            bitcnt_q    <= bitcnt_d;
            state_q     <= state_d;
            par_q       <= par_d;
            cnt_q       <= cnt_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
        end
    end

    assign par_out     = par_q;
    assign frame_valid = valid_q;
    assign frame_err   = err_q;
    assign busy        = busy_q;
    assign frame_cnt   = cnt_q;

endmodule

// File: tb/tb_seg_shift_rx.sv
// tb_seg_shift_rx: table-driven plus randomized bench for seg_shift_rx with a
// bit-queue reference model of the shift chain.
module tb_seg_shift_rx;

    localparam int W = 64;

    logic          clk = 1'b0;
    logic          RSTN = 1'b0;
    logic          s_clk = 1'b0;
    logic          s_dat = 1'b0;
    logic          s_pen = 1'b0;
    logic          s_clrn = 1'b1;
    logic [W-1:0]  par_out;
    logic          frame_valid;
    logic          frame_err;
    logic          busy;
    logic [15:0]   frame_cnt;

    seg_shift_rx #(.WIDTH(W), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .RSTN        (RSTN),
        .s_clk       (s_clk),
        .s_dat       (s_dat),
        .s_pen       (s_pen),
        .s_clrn      (s_clrn),
        .par_out     (par_out),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .busy        (busy),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int seen_v = 0;
    int seen_e = 0;

    // Reference model: the bits shifted since the last latch, clear or reset.
    bit          model_q[$];
    logic [63:0] exp_par = '0;
    logic [15:0] exp_cnt = '0;

    typedef struct {
        int          nbits;
        logic [63:0] data;
        bit          sim;
        bit          exp_v;
        bit          exp_e;
    } vec_t;
    vec_t tbl[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Pulse monitor: counts every strobe and checks they never coincide.
    always @(negedge clk) begin
        if (frame_valid === 1'b1) seen_v++;
        if (frame_err === 1'b1) seen_e++;
        if (frame_valid === 1'b1 || frame_err === 1'b1)
            check("valid_err_exclusive", 64'(frame_valid & frame_err), 64'd0);
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input bit b);
        s_dat = b;
        step(2);
        s_clk = 1'b1;
        model_q.push_back(b);
        step(4);
        s_clk = 1'b0;
        step(2);
    endtask

    task automatic send_frame(input int n, input logic [63:0] d);
        for (int i = 0; i < n; i++) begin
            send_bit((i < 64) ? d[63-i] : 1'b1);
            if (i == 0) check("busy_shifting", 64'(busy), 64'd1);
        end
    endtask

    // Latch decision from the spec's rules: exactly W bits commits, any other
    // nonzero count is an error, nothing pending is ignored.
    task automatic model_pen(output bit mv, output bit me);
        logic [63:0] v;
        mv = 1'b0;
        me = 1'b0;
        if (model_q.size() == W) begin
            v = '0;
            foreach (model_q[k]) v = {v[62:0], model_q[k]};
            exp_par = v;
            exp_cnt = exp_cnt + 16'd1;
            mv = 1'b1;
        end else if (model_q.size() > 0) begin
            me = 1'b1;
        end
        model_q.delete();
    endtask

    task automatic pen_check(input bit with_clk, input bit b, input bit use_tbl,
                             input bit tv, input bit te);
        bit mv, me;
        int v0, e0;
        if (with_clk) begin
            s_dat = b;
            step(2);
            model_q.push_back(b);
        end
        v0 = seen_v;
        e0 = seen_e;
        model_pen(mv, me);
        if (use_tbl) begin
            mv = tv;
            me = te;
        end
        s_pen = 1'b1;
        if (with_clk) s_clk = 1'b1;
        step(3);
        check("valid_at_latency", 64'(frame_valid), 64'(mv));
        check("err_at_latency", 64'(frame_err), 64'(me));
        step(1);
        check("valid_one_cycle", 64'(frame_valid), 64'd0);
        check("err_one_cycle", 64'(frame_err), 64'd0);
        s_clk = 1'b0;
        step(3);
        s_pen = 1'b0;
        step(5);
        check("par_out", par_out, exp_par);
        check("frame_cnt", 64'(frame_cnt), 64'(exp_cnt));
        check("busy_after_latch", 64'(busy), 64'd0);
        check("valid_pulse_count", 64'(seen_v - v0), 64'(mv));
        check("err_pulse_count", 64'(seen_e - e0), 64'(me));
    endtask

    initial begin
        logic [63:0] d;
        int          n;
        int          r;

        tbl[0] = '{64, 64'hDEADBEEF01234567, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{63, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{65, 64'hA5A5A5A55A5A5A5A, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{64, 64'h0F1E2D3C4B5A6978, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{64, 64'hCAFEF00D12345679, 1'b1, 1'b1, 1'b0};

        // Reset state.
        step(3);
        check("rst_par_out", par_out, 64'd0);
        check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(frame_valid), 64'd0);
        check("rst_err", 64'(frame_err), 64'd0);
        RSTN = 1'b1;
        step(3);

        // Table: full, short, long, full, and simultaneous 64th-bit/pen.
        for (int i = 0; i < 5; i++) begin
            d = tbl[i].data;
            if (tbl[i].sim) begin
                send_frame(63, d);
                pen_check(1'b1, d[0], 1'b1, tbl[i].exp_v, tbl[i].exp_e);
            end else begin
                send_frame(tbl[i].nbits, d);
                pen_check(1'b0, 1'b0, 1'b1, tbl[i].exp_v, tbl[i].exp_e);
            end
        end

        // Clear mid-frame.
        send_frame(20, 64'hFEDCBA9876543210);
        s_clrn = 1'b0;
        step(4);
        check("clr_par_out", par_out, 64'd0);
        check("clr_busy", 64'(busy), 64'd0);
        step(1);
        s_clrn = 1'b1;
        model_q.delete();
        exp_par = '0;
        step(4);
        check("clr_frame_cnt_held", 64'(frame_cnt), 64'(exp_cnt));
        send_frame(64, 64'h0123456789ABCDEF);
        pen_check(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized frames against the model.
        for (int k = 0; k < 12; k++) begin
            r = $urandom_range(0, 5);
            if (r <= 2) n = 64;
            else if (r == 3) n = 63;
            else if (r == 4) n = 65;
            else n = $urandom_range(0, 10);
            d = {$urandom, $urandom};
            send_frame(n, d);
            pen_check(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Reset mid-frame, then a lone pen, then a fresh frame.
        send_frame(40, 64'h1357924680ACEBDF);
        #2;
        RSTN = 1'b0;
        #1;
        check("async_rst_par_out", par_out, 64'd0);
        check("async_rst_frame_cnt", 64'(frame_cnt), 64'd0);
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_valid", 64'(frame_valid), 64'd0);
        check("async_rst_err", 64'(frame_err), 64'd0);
        step(3);
        RSTN = 1'b1;
        model_q.delete();
        exp_par = '0;
        exp_cnt = '0;
        step(3);
        pen_check(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(64, 64'h8000000000000001);
        pen_check(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("cnt_after_reset_frame", 64'(frame_cnt), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seg_shift_rx.md
# seg_shift_rx

Serial-to-parallel receiver for the display shift-chain interface the CPU top drives: it plays the board's shift-register chain. It consumes a serial clock, data, latch-enable and active-low clear, and presents the latched parallel frame, plus frame status and a valid-frame counter. Instances sit on the bench or on a listener board to check `SSeg7_Dev` (64-bit segment frames) and `SPIO` (LED frames) output. All serial inputs are asynchronous to `clk` and are oversampled.

## Interface
- `WIDTH`, 64: bits per frame; use 64 for the segment chain.
- `SYNC_STAGES`, 2: synchronizer flops per serial input; minimum 2.
- `clk` input 1: system clock; single clock domain.
- `RSTN` input 1: reset, asynchronous and active-low.
- `s_clk` input 1: serial shift clock; data is captured on its rising edge.
- `s_dat` input 1: serial data, MSB of the frame first.
- `s_pen` input 1: latch enable; the frame commits on its rising edge.
- `s_clrn` input 1: active-low clear from the transmitter; level-sensitive.
- `par_out` output WIDTH: last committed frame.
- `frame_valid` output 1: one-cycle pulse when a frame commits.
- `frame_err` output 1: one-cycle pulse when a latch arrives with a wrong bit count.
- `busy` output 1: high when the FSM is not in IDLE.
- `frame_cnt` output 16: count of committed frames; wraps from 0xFFFF to 0.

## Operation
- **Synchronization:** `s_clk`, `s_dat`, `s_pen` and `s_clrn` each pass through `SYNC_STAGES` flops. Edge detection compares the last sync stage with one extra flop.
- **Shift:** on a detected `s_clk` rise, `shreg <= {shreg[WIDTH-2:0], s_dat_sync}`.
- **Bit count:** `bitcnt` (width clog2(WIDTH+2)) increments on each shift and saturates at WIDTH+1.
- **FSM states:**
  - IDLE: `bitcnt`=0.
  - RECV: 1 ≤ `bitcnt` < WIDTH.
  - FULL: `bitcnt` = WIDTH.
  - OVER: `bitcnt` > WIDTH.
- **Transitions on a shift edge:** IDLE→RECV (or →FULL when WIDTH=1), RECV→FULL on the WIDTH-th bit, FULL→OVER, OVER→OVER.
- **Transitions on a `s_pen` rise:**
  - FULL: `par_out <= shreg`, pulse `frame_valid`, increment `frame_cnt`, go to IDLE.
  - RECV or OVER: pulse `frame_err`, leave `par_out` unchanged, go to IDLE.
  - IDLE: ignored, no pulse.
- **Simultaneous shift and pen edge (same cycle):** the shift is applied first. The latch decision uses the post-shift count and the new `shreg` contents, so the 64th bit arriving with `s_pen` still commits.
- **Clear:** while the synchronized `s_clrn` = 0:
  - `shreg`, `bitcnt` and `par_out` are forced to 0 and the FSM is held in IDLE.
  - Shift and pen edges are ignored.
  - `frame_cnt` is not affected.
  - Clear dominates any simultaneous edge.
- **Reset:** `RSTN` low, including mid-frame, immediately clears:
  - all synchronizer and edge flops to 0, with the `s_clrn` sync chain reset to 1;
  - `shreg`, `bitcnt`, `par_out`, `frame_cnt` to 0;
  - `frame_valid` and `frame_err` to 0, FSM to IDLE, `busy` to 0.
- **After reset release:** the first edges are detected against reset values. An `s_clk` already high at release produces one shift; the transmitter must hold `s_clk` low at reset release.

## Timing
- Pin-to-shift latency: an `s_clk` rise at the pin updates `shreg` at the (SYNC_STAGES+1)-th `clk` rising edge; 3 cycles by default.
- Pin-to-commit latency: an `s_pen` rise at the pin raises `frame_valid`/`frame_err`, updates `par_out`, increments `frame_cnt` and drops `busy` on the (SYNC_STAGES+1)-th edge.
- `s_pen` with no shift in the same cycle: the decision uses the count held in the prior cycle.
- All outputs are registered. `frame_valid` and `frame_err` are high for exactly one cycle and never together.
- Transmitter constraints:
  - `s_clk` high and low phases ≥ SYNC_STAGES+1 `clk` periods each.
  - `s_dat` stable from 1 `clk` period before to 1 `clk` period after each `s_clk` rise.
  - `s_pen` pulses ≥ SYNC_STAGES+1 periods wide.
- Throughput: one bit per 2·(SYNC_STAGES+1) cycles at most.

## Test plan
- **Full frame:** reset, then shift 0xDEADBEEF01234567 MSB first, then pulse `s_pen`. Required: `par_out`=0xDEADBEEF01234567, a single `frame_valid` pulse 3 cycles after the pen rise, `frame_cnt`=1, `busy` 1 during shifting and 0 after commit.
- **Short and long frames:** shift 63 bits of 0xFFFF… then pen, and shift 65 bits then pen. Required: each gives exactly one `frame_err` pulse and no `frame_valid`; `par_out` keeps the previous frame; `frame_cnt` unchanged; the next 64-bit frame commits normally.
- **Clear mid-frame:** drop `s_clrn` low for 5 cycles after 20 bits. Required: `par_out`=0 and `busy`=0 within 3 cycles; `frame_cnt` held. A following full frame 0x0123456789ABCDEF commits and `frame_cnt` increments.
- **Simultaneous edges:** raise `s_pen` in the same `clk` cycle as the 64th `s_clk` rise. Required: `frame_valid` with `par_out` including bit 0; no `frame_err`.
- **Reset and idle latch:** assert `RSTN` low after 40 bits of a frame. Required: all outputs 0 asynchronously. After release, an `s_pen` alone gives no pulse, and a full frame commits with `frame_cnt`=1.
